arbitro_rr: RTL

- Round-robin read arbiter sitting directly upstream of the 4:1 mux and downstream demux.
- Watches the empty flags of the four input FIFOs (entrada0..3) and pops at most one word per cycle.
- Drives selector_mux so the popped word reaches salida_mux one cycle later.
- Derives selector_dmux from the word's two MSBs and issues push, with backpressure from the four destination FIFOs.

---
 rtl/arbitro_rr.sv | 138 +++++++++++++
 1 files changed

// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin read arbiter between four input FIFOs and four
// destination FIFOs. Pops at most one word per cycle, steers the 4:1 mux
// with a registered select and pushes the word one cycle later towards the
// destination encoded in its two MSBs.
// Optional per-destination word counters: define ARBITRO_CONTADORES_EN.
module arbitro_rr #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enb,
  input  logic [3:0]            fifo_empty,
  input  logic [3:0]            destino_almost_full,
  input  logic [DATA_WIDTH-1:0] entrada_mux,
  output logic [3:0]            pop,
  output logic [1:0]            selector_mux,
  output logic [1:0]            selector_dmux,
  output logic                  push,
  output logic [1:0]            estado
`ifdef ARBITRO_CONTADORES_EN
  ,
  output logic [CNT_WIDTH-1:0]  contador0,
  output logic [CNT_WIDTH-1:0]  contador1,
  output logic [CNT_WIDTH-1:0]  contador2,
  output logic [CNT_WIDTH-1:0]  contador3
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ARBITRA = 2'b01,
    PAUSA   = 2'b10
  } estado_t;

  estado_t    estado_q;
  estado_t    estado_d;
  logic [1:0] ultimo;
  logic [1:0] grant_idx;
  logic [1:0] candidato;
  logic       encontrado;
  logic       hay_datos;
  logic       lleno;
  logic       concede;

  // Any non-empty source is work to do; any nearly full sink stalls everyone.
  assign hay_datos = |(~fifo_empty);
  assign lleno     = |destino_almost_full;
  assign concede   = (estado_q == ARBITRA) && enb && hay_datos && !lleno;

  // Search the sources starting just after the last grant, wrapping 3 -> 0.
  always_comb begin
    grant_idx  = ultimo;
    candidato  = ultimo;
    encontrado = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      candidato = ultimo + 2'(k);
      if (!encontrado && !fifo_empty[candidato]) begin
        grant_idx  = candidato;
        encontrado = 1'b1;
      end
    end
  end

  assign pop = concede ? (4'b0001 << grant_idx) : 4'b0000;

  // Next-state logic for the IDLE / ARBITRA / PAUSA controller.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      IDLE: begin
        if (enb && hay_datos) begin
          estado_d = lleno ? PAUSA : ARBITRA;
        end
      end
      ARBITRA: begin
        if (lleno) begin
          estado_d = PAUSA;
        end else if (!enb || !hay_datos) begin
          estado_d = IDLE;
        end
      end
      PAUSA: begin
        if (!lleno) begin
          estado_d = (enb && hay_datos) ? ARBITRA : IDLE;
        end
      end
      default: estado_d = IDLE;
    endcase
  end

  // State register plus the pop-to-push pipeline; a pop always yields a push
  // on the following cycle so the in-flight word is never lost (except reset).
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= IDLE;
      ultimo       <= 2'd3;
      selector_mux <= 2'd0;
      push         <= 1'b0;
    end else begin
      estado_q <= estado_d;
      push     <= concede;
      if (concede) begin
        ultimo       <= grant_idx;
        selector_mux <= grant_idx;
      end
    end
  end

  assign estado        = estado_q;
  assign selector_dmux = push ? entrada_mux[DATA_WIDTH-1:DATA_WIDTH-2] : 2'b00;

`ifdef ARBITRO_CONTADORES_EN
  logic [CNT_WIDTH-1:0] cuenta [4];
  logic                 unused_bits;

  // Count words delivered to each destination, wrapping naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 4; j++) begin
        cuenta[j] <= '0;
      end
    end else if (push) begin
      cuenta[selector_dmux] <= cuenta[selector_dmux] + CNT_WIDTH'(1);
    end
  end

  assign contador0   = cuenta[0];
  assign contador1   = cuenta[1];
  assign contador2   = cuenta[2];
  assign contador3   = cuenta[3];
  assign unused_bits = ^entrada_mux;
`else
  logic unused_bits;
  assign unused_bits = ^{entrada_mux, 32'(CNT_WIDTH)};
`endif

endmodule
